// File: rtl/word_assembler_if.sv
// Byte-in / word-out handshake bundle for word_assembler.
`default_nettype none

interface word_assembler_if #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_byte;
  logic              in_last;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_word;
  logic [2:0]        out_count;

  modport master (
    output in_valid, in_byte, in_last, flush, out_ready,
    input  in_ready, out_valid, out_word, out_count
  );

  modport slave (
    input  in_valid, in_byte, in_last, flush, out_ready,
    output in_ready, out_valid, out_word, out_count
  );
endinterface

`default_nettype wire

// File: rtl/word_assembler.sv
// ============================================================================
// word_assembler : packs a byte stream little-endian into DATA_W-bit words
// Revision       : 1.0
// ============================================================================
`default_nettype none

module word_assembler #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  word_assembler_if.slave bus
);
  localparam int LANES = DATA_W / BYTE_W;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] out_word;
  logic [2:0]        out_count;
  logic              out_valid;
  logic              in_ready;
  logic              accept;
  logic              complete;

  // Ready never looks at in_valid/in_last, so no combinational loop upstream.
  assign in_ready = !bus.flush && (!out_valid || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign complete = accept && (bus.in_last || (cnt == LAST_LANE));

  always_comb begin
    merged = acc;
    for (int k = 0; k < LANES; k++) begin
      if (k == int'(cnt)) begin
        merged[k*BYTE_W +: BYTE_W] = bus.in_byte;
      end else if (k > int'(cnt)) begin
        merged[k*BYTE_W +: BYTE_W] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      out_word  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      // A completion later in this block overrides the pop, so back-to-back words have no bubble.
      if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
      if (bus.flush) begin
        cnt <= '0;
        acc <= '0;
      end else if (complete) begin
        out_word  <= merged;
        out_count <= 3'(cnt) + 3'd1;
        out_valid <= 1'b1;
        cnt       <= '0;
        acc       <= '0;
      end else if (accept) begin
        acc <= merged;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_word  = out_word;
  assign bus.out_count = out_count;

endmodule

`default_nettype wire
